cr16_control_fsm: RTL and testbench
===================================

# cr16_control_fsm

Multi-cycle fetch/decode/execute controller sitting directly upstream of `cr16_datapath`. Fetches 16-bit instructions from instruction memory over a request/valid handshake, decodes them, and drives every datapath control input (register selects, one-hot write enable, immediate and immediate select, ALU opcode, enable). Also owns the program counter and evaluates branches from the datapath status flags.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `I_CLK`  in  1  system clock; all state updates on the rising edge.
- `I_RESET`  in  1  synchronous, active-high reset.
- `I_ENABLE`  in  1  global advance enable; low freezes all state.
- `I_MEM_RDATA`  in  16  instruction word; valid when `I_MEM_RVALID`=1.
- `I_MEM_RVALID`  in  1  memory read-data valid.
- `I_STATUS_FLAGS`  in  5  datapath flags {N,Z,F,L,C} = bits [4:0].
- `O_MEM_ADDR`  out  16  fetch address (equals PC).
- `O_MEM_RREQ`  out  1  fetch request.
- `O_REG_WRITE_ENABLE`  out  16  one-hot register write enable to datapath.
- `O_REG_A_SELECT`  out  4  datapath A operand register.
- `O_REG_B_SELECT`  out  4  datapath B operand register.
- `O_IMMEDIATE_SELECT`  out  1  1 = B operand replaced by `O_IMMEDIATE`.
- `O_IMMEDIATE`  out  16  extended immediate.
- `O_OPCODE`  out  4  datapath ALU opcode.
- `O_DP_ENABLE`  out  1  datapath enable.
- `O_HALTED`  out  1  high while in HALT.
- `O_ILLEGAL`  out  1  one-cycle pulse on undecodable instruction.

## Operation
- Format: [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc; imm8 = [7:0].
- ALU opcodes: ADD 0000, SUB 0100, AND 0110, OR 0111, XOR 1000, NOT 1001, LSH 1010.
- op 0000 R-type: A=Rdest, B=Rsrc, `O_OPCODE`=ext (passed through unchecked), write Rdest.
- op 0001 ADDI / 0010 SUBI: A=Rdest, imm = sign-extended imm8, ADD/SUB, write Rdest.
- op 0011 ANDI / 0100 ORI / 0101 XORI: imm zero-extended, AND/OR/XOR, write Rdest.
- op 1100 BZ: taken if `I_STATUS_FLAGS[3]`=1; op 1101 BR: always taken. Target = PC + sext(imm8), mod 2^16.
- op 1111 HALT. All other ops: NOP, `O_ILLEGAL` pulses during EXECUTE, PC += 1.
- States: FETCH -> DECODE -> EXECUTE -> FETCH; DECODE -> BRANCH -> FETCH for 1100/1101; DECODE -> HALT for 1111.
- FETCH: `O_MEM_RREQ`=1, `O_MEM_ADDR`=PC; on edge with `I_MEM_RVALID`=1, IR <= `I_MEM_RDATA`, go DECODE.
- DECODE: register selects/immediate/opcode driven from IR; write enable 0.
- EXECUTE: same controls plus exactly one `O_REG_WRITE_ENABLE` bit (bit Rdest) for one cycle; PC += 1 (0xFFFF wraps to 0x0000).
- BRANCH: PC <= taken ? target : PC+1; no register write.
- HALT: `O_HALTED`=1, PC frozen, no requests; exit only by reset.

## Timing
- Reset values: PC=`RESET_PC`, IR=0, state FETCH, all control outputs 0, `O_MEM_ADDR`=`RESET_PC`, `O_HALTED`=0, `O_ILLEGAL`=0; `O_MEM_RREQ` rises the first cycle after reset deasserts.
- Minimum ALU instruction = 3 cycles (RVALID in first FETCH cycle); branch = 3 cycles.
- `O_MEM_ADDR` stable and `O_MEM_RREQ` held for the entire FETCH state regardless of wait length.
- `I_MEM_RVALID` outside FETCH, or on a cycle with `I_RESET`=1, ignored.
- `I_ENABLE`=0: no state/PC/IR change, `O_REG_WRITE_ENABLE` forced 0, `O_DP_ENABLE`=0, `O_ILLEGAL` suppressed; other outputs hold. EXECUTE resumes and writes once when re-enabled.
- `I_RESET` wins over `I_ENABLE` and any state, including mid-FETCH and HALT.
- `O_DP_ENABLE`=1 in DECODE and EXECUTE only.

## Configuration
- `CR16_CONTROL_BRANCH_EN` defined: BZ/BR decoded and BRANCH state present.
- Undefined: ops 1100/1101 are illegal (NOP, `O_ILLEGAL` pulse, PC += 1); BRANCH state and `I_STATUS_FLAGS` logic absent.

## Test plan
- Reset then memory returns 16'h1205 (ADDI R2,5) with RVALID after 2 wait cycles -> `O_MEM_ADDR`=0 held 3 cycles; EXECUTE shows A=2, imm=16'h0005, select=1, opcode=0000, write enable=16'h0004 for one cycle; PC=1.
- 16'h21FF (SUBI R1,-1) -> imm=16'hFFFF, opcode=0100, write enable=16'h0002; 16'h3380 (ANDI) -> imm=16'h0080.
- R-type 16'h0473 (R4 = R4 XOR? ext=7 OR R3) -> A=4, B=3, select=0, opcode=0111, write enable=16'h0010.
- BZ 16'hC0FE at PC=0x0010 with flags=5'b01000 -> next fetch 0x000E; flags=0 -> 0x0011; BR at PC=0xFFFF, imm 0x01 -> 0x0000. Without macro: `O_ILLEGAL` pulse, next fetch PC+1.
- `I_ENABLE` low 4 cycles during EXECUTE -> no write enable, then exactly one 1-cycle write after re-enable.
- HALT 16'hF000 -> `O_HALTED`=1, `O_MEM_RREQ`=0 for 10 cycles; `I_RESET` mid-FETCH with RVALID asserted -> IR not loaded, PC=`RESET_PC`.

Source files
------------

// File: rtl/cr16_control_fsm.sv
// Fetch/decode/execute controller for cr16_datapath: owns PC and IR, drives all datapath controls.
// Define CR16_CONTROL_BRANCH_EN to decode BZ/BR (ops 1100/1101) and add the BRANCH state.
module cr16_control_fsm #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic        I_ENABLE,
   input  logic [15:0] I_MEM_RDATA,
   input  logic        I_MEM_RVALID,
   input  logic [4:0]  I_STATUS_FLAGS,
   output logic [15:0] O_MEM_ADDR,
   output logic        O_MEM_RREQ,
   output logic [15:0] O_REG_WRITE_ENABLE,
   output logic [3:0]  O_REG_A_SELECT,
   output logic [3:0]  O_REG_B_SELECT,
   output logic        O_IMMEDIATE_SELECT,
   output logic [15:0] O_IMMEDIATE,
   output logic [3:0]  O_OPCODE,
   output logic        O_DP_ENABLE,
   output logic        O_HALTED,
   output logic        O_ILLEGAL
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_HALT    = 3'd3
`ifdef CR16_CONTROL_BRANCH_EN
      , S_BRANCH = 3'd4
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;

   logic [3:0]  op, rd, ext, rs;
   logic [15:0] sext_imm, zext_imm;
   logic        writes_rd, illegal_op, is_halt, dec_sel;
   logic [15:0] dec_imm;
   logic [3:0]  dec_opc;
   logic        show_ctrl;
   logic        unused_flags;

   assign op       = ir_q[15:12];
   assign rd       = ir_q[11:8];
   assign ext      = ir_q[7:4];
   assign rs       = ir_q[3:0];
   assign sext_imm = {{8{ir_q[7]}}, ir_q[7:0]};
   assign zext_imm = {8'h00, ir_q[7:0]};

`ifdef CR16_CONTROL_BRANCH_EN
   logic is_branch;
   logic br_taken;
   // BR (1101) is unconditional; BZ (1100) follows the Z flag.
   assign br_taken     = (op == 4'hD) || I_STATUS_FLAGS[3];
   assign unused_flags = ^{I_STATUS_FLAGS[4], I_STATUS_FLAGS[2:0]};
`else
   assign unused_flags = ^I_STATUS_FLAGS;
`endif

   always_comb begin
      writes_rd  = 1'b0;
      illegal_op = 1'b0;
      is_halt    = 1'b0;
      dec_sel    = 1'b0;
      dec_imm    = 16'h0000;
      dec_opc    = 4'h0;
`ifdef CR16_CONTROL_BRANCH_EN
      is_branch  = 1'b0;
`endif
      case (op)
         4'h0: begin writes_rd = 1'b1; dec_opc = ext; end
         4'h1: begin writes_rd = 1'b1; dec_sel = 1'b1; dec_imm = sext_imm; dec_opc = 4'b0000; end
         4'h2: begin writes_rd = 1'b1; dec_sel = 1'b1; dec_imm = sext_imm; dec_opc = 4'b0100; end
         4'h3: begin writes_rd = 1'b1; dec_sel = 1'b1; dec_imm = zext_imm; dec_opc = 4'b0110; end
         4'h4: begin writes_rd = 1'b1; dec_sel = 1'b1; dec_imm = zext_imm; dec_opc = 4'b0111; end
         4'h5: begin writes_rd = 1'b1; dec_sel = 1'b1; dec_imm = zext_imm; dec_opc = 4'b1000; end
`ifdef CR16_CONTROL_BRANCH_EN
         4'hC, 4'hD: begin is_branch = 1'b1; dec_imm = sext_imm; end
`endif
         4'hF: is_halt = 1'b1;
         default: illegal_op = 1'b1;
      endcase
   end

   // Controls are visible only while the instruction is in DECODE/EXECUTE; zero elsewhere.
   assign show_ctrl = (state_q == S_DECODE) || (state_q == S_EXECUTE);

   always_comb begin
      O_MEM_ADDR         = pc_q;
      O_MEM_RREQ         = (state_q == S_FETCH) && !I_RESET;
      O_HALTED           = (state_q == S_HALT);
      O_DP_ENABLE        = I_ENABLE && show_ctrl;
      O_REG_A_SELECT     = 4'h0;
      O_REG_B_SELECT     = 4'h0;
      O_IMMEDIATE_SELECT = 1'b0;
      O_IMMEDIATE        = 16'h0000;
      O_OPCODE           = 4'h0;
      O_REG_WRITE_ENABLE = 16'h0000;
      O_ILLEGAL          = 1'b0;
      if (show_ctrl) begin
         O_REG_A_SELECT     = rd;
         O_REG_B_SELECT     = rs;
         O_IMMEDIATE_SELECT = dec_sel;
         O_IMMEDIATE        = dec_imm;
         O_OPCODE           = dec_opc;
      end
      if ((state_q == S_EXECUTE) && I_ENABLE) begin
         O_REG_WRITE_ENABLE = writes_rd ? (16'h0001 << rd) : 16'h0000;
         O_ILLEGAL          = illegal_op;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      if (I_ENABLE) begin
         case (state_q)
            S_FETCH: begin
               if (I_MEM_RVALID) begin
                  ir_d    = I_MEM_RDATA;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               if (is_halt) begin
                  state_d = S_HALT;
`ifdef CR16_CONTROL_BRANCH_EN
               end else if (is_branch) begin
                  state_d = S_BRANCH;
`endif
               end else begin
                  state_d = S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               pc_d    = pc_q + 16'd1;
               state_d = S_FETCH;
            end
`ifdef CR16_CONTROL_BRANCH_EN
            S_BRANCH: begin
               pc_d    = br_taken ? (pc_q + sext_imm) : (pc_q + 16'd1);
               state_d = S_FETCH;
            end
`endif
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Directed plus randomized bench for cr16_control_fsm against an instruction-level reference model.
module tb_cr16_control_fsm;

   logic        I_CLK = 1'b0;
   logic        I_RESET, I_ENABLE, I_MEM_RVALID;
   logic [15:0] I_MEM_RDATA;
   logic [4:0]  I_STATUS_FLAGS;
   logic [15:0] O_MEM_ADDR, O_REG_WRITE_ENABLE, O_IMMEDIATE;
   logic        O_MEM_RREQ, O_IMMEDIATE_SELECT, O_DP_ENABLE, O_HALTED, O_ILLEGAL;
   logic [3:0]  O_REG_A_SELECT, O_REG_B_SELECT, O_OPCODE;

   always #5 I_CLK = ~I_CLK;

   cr16_control_fsm dut (
      .I_CLK(I_CLK), .I_RESET(I_RESET), .I_ENABLE(I_ENABLE),
      .I_MEM_RDATA(I_MEM_RDATA), .I_MEM_RVALID(I_MEM_RVALID), .I_STATUS_FLAGS(I_STATUS_FLAGS),
      .O_MEM_ADDR(O_MEM_ADDR), .O_MEM_RREQ(O_MEM_RREQ), .O_REG_WRITE_ENABLE(O_REG_WRITE_ENABLE),
      .O_REG_A_SELECT(O_REG_A_SELECT), .O_REG_B_SELECT(O_REG_B_SELECT),
      .O_IMMEDIATE_SELECT(O_IMMEDIATE_SELECT), .O_IMMEDIATE(O_IMMEDIATE), .O_OPCODE(O_OPCODE),
      .O_DP_ENABLE(O_DP_ENABLE), .O_HALTED(O_HALTED), .O_ILLEGAL(O_ILLEGAL)
   );

`ifdef CR16_CONTROL_BRANCH_EN
   localparam bit BR_EN = 1'b1;
`else
   localparam bit BR_EN = 1'b0;
`endif
   localparam logic [1:0] K_ALU = 2'd0, K_ILL = 2'd1, K_BR = 2'd2, K_HALT = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [3:0]  a;
      logic [3:0]  b;
      logic        chk_b;
      logic        sel;
      logic [15:0] imm;
      logic [3:0]  opc;
      logic [15:0] we;
      logic [15:0] next_pc;
   } exp_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] model_pc;

   // Instruction semantics computed with plain integer arithmetic.
   function automatic exp_t model(input logic [15:0] w, input logic [15:0] pc, input logic [4:0] flags);
      exp_t e;
      int op, rd, rs, ext, imm8, simm;
      op   = int'(w[15:12]);
      rd   = int'(w[11:8]);
      ext  = int'(w[7:4]);
      rs   = int'(w[3:0]);
      imm8 = int'(w[7:0]);
      simm = (imm8 >= 128) ? imm8 - 256 : imm8;
      e = '0;
      e.next_pc = 16'((int'(pc) + 1) % 65536);
      if (op <= 5) begin
         e.kind = K_ALU;
         e.a    = 4'(rd);
         e.we   = 16'(1 << rd);
         e.sel  = (op != 0);
         case (op)
            0: begin e.opc = 4'(ext); e.b = 4'(rs); e.chk_b = 1'b1; end
            1: begin e.opc = 4'd0; e.imm = 16'((simm + 65536) % 65536); end
            2: begin e.opc = 4'd4; e.imm = 16'((simm + 65536) % 65536); end
            3: begin e.opc = 4'd6; e.imm = 16'(imm8); end
            4: begin e.opc = 4'd7; e.imm = 16'(imm8); end
            default: begin e.opc = 4'd8; e.imm = 16'(imm8); end
         endcase
      end else if (op == 15) begin
         e.kind = K_HALT;
      end else if (BR_EN && (op == 12 || op == 13)) begin
         e.kind = K_BR;
         if (op == 13 || flags[3])
            e.next_pc = 16'((int'(pc) + simm + 65536) % 65536);
      end else begin
         e.kind = K_ILL;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge I_CLK);
      #2;
   endtask

   task automatic chk_ctrl(input exp_t e);
      chk("a_select", 16'(O_REG_A_SELECT), 16'(e.a));
      chk("opcode", 16'(O_OPCODE), 16'(e.opc));
      chk("imm_select", 16'(O_IMMEDIATE_SELECT), 16'(e.sel));
      if (e.chk_b) chk("b_select", 16'(O_REG_B_SELECT), 16'(e.b));
      if (e.sel) chk("immediate", O_IMMEDIATE, e.imm);
   endtask

   task automatic do_reset(input bit rvalid_during);
      I_RESET      = 1'b1;
      I_ENABLE     = 1'($urandom_range(0, 1));
      I_MEM_RVALID = rvalid_during;
      I_MEM_RDATA  = 16'hF000;
      tick();
      tick();
      #1;
      chk("rst_rreq", 16'(O_MEM_RREQ), 16'h0);
      chk("rst_addr", O_MEM_ADDR, 16'h0000);
      chk("rst_we", O_REG_WRITE_ENABLE, 16'h0000);
      chk("rst_dp_en", 16'(O_DP_ENABLE), 16'h0);
      chk("rst_halted", 16'(O_HALTED), 16'h0);
      chk("rst_illegal", 16'(O_ILLEGAL), 16'h0);
      chk("rst_ctrl", {O_REG_A_SELECT, O_REG_B_SELECT, O_OPCODE, 3'b000, O_IMMEDIATE_SELECT}, 16'h0000);
      chk("rst_imm", O_IMMEDIATE, 16'h0000);
      I_RESET      = 1'b0;
      I_ENABLE     = 1'b1;
      I_MEM_RVALID = 1'b0;
      #1;
      chk("post_rst_rreq", 16'(O_MEM_RREQ), 16'h1);
      chk("post_rst_addr", O_MEM_ADDR, 16'h0000);
      model_pc = 16'h0000;
   endtask

   // One instruction from FETCH back to FETCH (or into HALT); waits are FETCH cycles before data.
   task automatic run(input logic [15:0] w, input int waits, input logic [4:0] flags, input int stall);
      exp_t e;
      e = model(w, model_pc, flags);
      I_STATUS_FLAGS = flags;
      for (int i = 0; i < waits; i++) begin
         // A wait cycle either has no data, or has data while frozen (must not be taken).
         I_MEM_RVALID = 1'($urandom_range(0, 1));
         I_MEM_RDATA  = 16'($urandom);
         I_ENABLE     = ~I_MEM_RVALID;
         #1;
         chk("fetch_rreq", 16'(O_MEM_RREQ), 16'h1);
         chk("fetch_addr", O_MEM_ADDR, model_pc);
         tick();
      end
      I_ENABLE     = 1'b1;
      I_MEM_RVALID = 1'b1;
      I_MEM_RDATA  = w;
      #1;
      chk("fetch_rreq", 16'(O_MEM_RREQ), 16'h1);
      chk("fetch_addr", O_MEM_ADDR, model_pc);
      tick();
      I_MEM_RVALID = 1'($urandom_range(0, 1));
      I_MEM_RDATA  = 16'($urandom);
      #1;
      chk("dec_dp_en", 16'(O_DP_ENABLE), 16'h1);
      chk("dec_we", O_REG_WRITE_ENABLE, 16'h0000);
      chk("dec_rreq", 16'(O_MEM_RREQ), 16'h0);
      chk("dec_illegal", 16'(O_ILLEGAL), 16'h0);
      if (e.kind == K_ALU) chk_ctrl(e);
      tick();
      if (e.kind == K_HALT) begin
         for (int i = 0; i < 10; i++) begin
            I_MEM_RVALID = 1'($urandom_range(0, 1));
            #1;
            chk("halt_halted", 16'(O_HALTED), 16'h1);
            chk("halt_rreq", 16'(O_MEM_RREQ), 16'h0);
            chk("halt_addr", O_MEM_ADDR, model_pc);
            chk("halt_we", O_REG_WRITE_ENABLE, 16'h0000);
            tick();
         end
         I_MEM_RVALID = 1'b0;
      end else if (e.kind == K_BR) begin
         I_MEM_RVALID = 1'b0;
         #1;
         chk("br_we", O_REG_WRITE_ENABLE, 16'h0000);
         chk("br_dp_en", 16'(O_DP_ENABLE), 16'h0);
         chk("br_rreq", 16'(O_MEM_RREQ), 16'h0);
         tick();
         #1;
         chk("br_next_rreq", 16'(O_MEM_RREQ), 16'h1);
         chk("br_next_addr", O_MEM_ADDR, e.next_pc);
         model_pc = e.next_pc;
      end else begin
         I_MEM_RVALID = 1'b0;
         if (stall > 0) begin
            I_ENABLE = 1'b0;
            for (int i = 0; i < stall; i++) begin
               #1;
               chk("stall_we", O_REG_WRITE_ENABLE, 16'h0000);
               chk("stall_dp_en", 16'(O_DP_ENABLE), 16'h0);
               chk("stall_illegal", 16'(O_ILLEGAL), 16'h0);
               tick();
            end
            I_ENABLE = 1'b1;
         end
         #1;
         chk("ex_we", O_REG_WRITE_ENABLE, (e.kind == K_ALU) ? e.we : 16'h0000);
         chk("ex_illegal", 16'(O_ILLEGAL), 16'(e.kind == K_ILL));
         chk("ex_dp_en", 16'(O_DP_ENABLE), 16'h1);
         if (e.kind == K_ALU) chk_ctrl(e);
         tick();
         #1;
         chk("next_we", O_REG_WRITE_ENABLE, 16'h0000);
         chk("next_illegal", 16'(O_ILLEGAL), 16'h0);
         chk("next_rreq", 16'(O_MEM_RREQ), 16'h1);
         chk("next_addr", O_MEM_ADDR, e.next_pc);
         model_pc = e.next_pc;
      end
   endtask

   function automatic logic [15:0] rand_alu();
      logic [3:0] op;
      op = 4'($urandom_range(0, 5));
      return {op, 12'($urandom)};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] w;
      I_RESET = 1'b1; I_ENABLE = 1'b1; I_MEM_RVALID = 1'b0;
      I_MEM_RDATA = 16'h0000; I_STATUS_FLAGS = 5'b00000;
      model_pc = 16'h0000;
      do_reset(1'b0);

      run(16'h1205, 2, 5'b00000, 0);
      chk("addi_pc", O_MEM_ADDR, 16'h0001);
      run(16'h21FF, 0, 5'b00000, 0);
      run(16'h3380, 1, 5'b00000, 0);
      run(16'h0473, 0, 5'b00000, 0);
      run(16'h1A7F, 0, 5'b00000, 4);
      run(16'h7000, 0, 5'b00000, 3);

      for (int n = 0; n < 40; n++) begin
         w = {4'($urandom_range(0, 14)), 12'($urandom)};
         run(w, $urandom_range(0, 3), 5'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      do_reset(1'b1);
      for (int n = 0; n < 16; n++) run(rand_alu(), $urandom_range(0, 2), 5'b00000, 0);
      chk("pc_at_0x10", O_MEM_ADDR, 16'h0010);
      run(16'hC0FE, 0, 5'b01000, 0);
`ifdef CR16_CONTROL_BRANCH_EN
      chk("bz_taken_addr", O_MEM_ADDR, 16'h000E);
      run(rand_alu(), 0, 5'b00000, 0);
      run(rand_alu(), 0, 5'b00000, 0);
      run(16'hC0FE, 0, 5'b00000, 0);
      chk("bz_not_taken_addr", O_MEM_ADDR, 16'h0011);
      run(16'hD080, 1, 5'b00000, 0);
      chk("br_back_addr", O_MEM_ADDR, 16'hFF91);
      for (int n = 0; n < 200 && model_pc != 16'hFFFF; n++) run(rand_alu(), 0, 5'($urandom), 0);
      chk("pc_at_ffff", O_MEM_ADDR, 16'hFFFF);
      run(16'hD001, 0, 5'b00000, 0);
      chk("br_wrap_addr", O_MEM_ADDR, 16'h0000);
      run(16'hD0FF, 0, 5'b00000, 0);
      run(rand_alu(), 0, 5'b00000, 0);
      chk("exec_wrap_addr", O_MEM_ADDR, 16'h0000);
`else
      chk("bz_illegal_addr", O_MEM_ADDR, 16'h0011);
      run(16'hD001, 0, 5'b01000, 0);
      chk("br_illegal_addr", O_MEM_ADDR, 16'h0012);
`endif

      run(16'hF000, 1, 5'b00000, 0);
      do_reset(1'b0);
      run(16'h5C3C, 0, 5'b00000, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
